// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default widths,
// HI/LO internal indices and the clear-engine state encoding.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // HI and LO live just above the GPRs in the internal array.
    localparam int HI_IDX = 2 ** ADDR_W_DEF;
    localparam int LO_IDX = 2 ** ADDR_W_DEF + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    function automatic int hi_index(input int aw);
        return 2 ** aw;
    endfunction

    function automatic int lo_index(input int aw);
        return 2 ** aw + 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per GPR plus one for HI/LO.
// With REGFILE_BYPASS_EN defined, a same-cycle writeback masks the busy lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_hilo,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              hilo_we,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              hilo_busy
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_s;
    logic            hilo_busy_r;
    logic            hilo_busy_s;
    logic            rs_drop_s;
    logic            rt_drop_s;
    logic            hilo_drop_s;

    // Next busy state: clear-all beats issue, and issue beats writeback.
    always_comb begin
        busy_s      = busy_r;
        hilo_busy_s = hilo_busy_r;
        if (clr) begin
            busy_s      = {NREG{1'b0}};
            hilo_busy_s = 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (issue_we && (issue_rd == ADDR_W'(i)) && (i != 0)) begin
                    busy_s[i] = 1'b1;
                end else if (wb_we && (wb_rd == ADDR_W'(i))) begin
                    busy_s[i] = 1'b0;
                end else begin
                    busy_s[i] = busy_r[i];
                end
            end
            if (issue_hilo) begin
                hilo_busy_s = 1'b1;
            end else if (hilo_we) begin
                hilo_busy_s = 1'b0;
            end else begin
                hilo_busy_s = hilo_busy_r;
            end
        end
    end

    // Busy vector register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r      <= {NREG{1'b0}};
            hilo_busy_r <= 1'b0;
        end else begin
            busy_r      <= busy_s;
            hilo_busy_r <= hilo_busy_s;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rs_drop_s   = wb_we && (wb_rd == rs) && !(issue_we && (issue_rd == rs));
    assign rt_drop_s   = wb_we && (wb_rd == rt) && !(issue_we && (issue_rd == rt));
    assign hilo_drop_s = hilo_we && !issue_hilo;
`else
    assign rs_drop_s   = 1'b0;
    assign rt_drop_s   = 1'b0;
    assign hilo_drop_s = 1'b0;
`endif

    assign rs_busy   = busy_r[rs] && (rs != {ADDR_W{1'b0}}) && !rs_drop_s;
    assign rt_busy   = busy_r[rt] && (rt != {ADDR_W{1'b0}}) && !rt_drop_s;
    assign hilo_busy = hilo_busy_r && !hilo_drop_s;

endmodule

// File: rtl/regfile_sb.sv
// GPR + HI/LO register file with pending-write scoreboard and sequential clear engine.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] regfile_out1,
    output logic [DATA_W-1:0] regfile_out2,
    output logic [DATA_W-1:0] high_out,
    output logic [DATA_W-1:0] low_out,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              hilo_we,
    input  logic [DATA_W-1:0] hi_data,
    input  logic [DATA_W-1:0] lo_data,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_hilo,
    input  logic              flush,
    input  logic              clear_req,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              hilo_busy,
    output logic              clear_busy
);

    localparam int NREG    = 2 ** ADDR_W;
    localparam int IW      = ADDR_W + 1;
    localparam int HI_SLOT = hi_index(ADDR_W);
    localparam int LO_SLOT = lo_index(ADDR_W);

    logic [DATA_W-1:0] mem_r [NREG+2];
    clr_state_e        state_r;
    clr_state_e        state_s;
    logic [IW-1:0]     idx_r;
    logic [IW-1:0]     idx_s;
    logic              clr_entry_s;
    logic              wb_ok_s;
    logic              hilo_ok_s;
    logic              issue_ok_s;
    logic              issue_hilo_ok_s;
    logic              fwd1_s;
    logic              fwd2_s;
    logic              fwd_hilo_s;

    assign clear_busy      = (state_r == CLEAR);
    assign wb_ok_s         = wb_we && !clear_busy;
    assign hilo_ok_s       = hilo_we && !clear_busy;
    assign issue_ok_s      = issue_we && !clear_busy;
    assign issue_hilo_ok_s = issue_hilo && !clear_busy;

    // Clear engine next state: walk GPRs, then HI, then LO, one per cycle.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        clr_entry_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_req) begin
                    state_s     = CLEAR;
                    idx_s       = {IW{1'b0}};
                    clr_entry_s = 1'b1;
                end else begin
                    state_s = IDLE;
                    idx_s   = idx_r;
                end
            end
            CLEAR: begin
                idx_s = idx_r + IW'(1);
                if (idx_r == IW'(LO_SLOT)) begin
                    state_s = IDLE;
                end else begin
                    state_s = CLEAR;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = {IW{1'b0}};
            end
        endcase
    end

    // Clear engine state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= {IW{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Data array: sequential clear while active, otherwise GPR and HI/LO writeback.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG + 2; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (clear_busy) begin
            mem_r[idx_r] <= {DATA_W{1'b0}};
        end else begin
            if (wb_we && (wb_rd != {ADDR_W{1'b0}})) begin
                mem_r[{1'b0, wb_rd}] <= wb_data;
            end
            if (hilo_we) begin
                mem_r[HI_SLOT] <= hi_data;
                mem_r[LO_SLOT] <= lo_data;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd1_s     = wb_ok_s && (wb_rd == rs);
    assign fwd2_s     = wb_ok_s && (wb_rd == rt);
    assign fwd_hilo_s = hilo_ok_s;
`else
    assign fwd1_s     = 1'b0;
    assign fwd2_s     = 1'b0;
    assign fwd_hilo_s = 1'b0;
`endif

    // Combinational read ports; index 0 is hardwired zero.
    always_comb begin
        regfile_out1 = {DATA_W{1'b0}};
        regfile_out2 = {DATA_W{1'b0}};
        if (rs == {ADDR_W{1'b0}}) begin
            regfile_out1 = {DATA_W{1'b0}};
        end else if (fwd1_s) begin
            regfile_out1 = wb_data;
        end else begin
            regfile_out1 = mem_r[{1'b0, rs}];
        end
        if (rt == {ADDR_W{1'b0}}) begin
            regfile_out2 = {DATA_W{1'b0}};
        end else if (fwd2_s) begin
            regfile_out2 = wb_data;
        end else begin
            regfile_out2 = mem_r[{1'b0, rt}];
        end
    end

    // HI/LO read with optional same-cycle forwarding.
    always_comb begin
        high_out = mem_r[HI_SLOT];
        low_out  = mem_r[LO_SLOT];
        if (fwd_hilo_s) begin
            high_out = hi_data;
            low_out  = lo_data;
        end else begin
            high_out = mem_r[HI_SLOT];
            low_out  = mem_r[LO_SLOT];
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .clr        (flush || clr_entry_s),
        .issue_we   (issue_ok_s),
        .issue_rd   (issue_rd),
        .issue_hilo (issue_hilo_ok_s),
        .wb_we      (wb_ok_s),
        .wb_rd      (wb_rd),
        .hilo_we    (hilo_ok_s),
        .rs         (rs),
        .rt         (rt),
        .rs_busy    (rs_busy),
        .rt_busy    (rt_busy),
        .hilo_busy  (hilo_busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// checked against an array-based reference model (honours REGFILE_BYPASS_EN).
module tb_regfile_sb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] rs, rt, wb_rd, issue_rd;
    logic [DW-1:0] regfile_out1, regfile_out2, high_out, low_out;
    logic [DW-1:0] wb_data, hi_data, lo_data;
    logic          wb_we, hilo_we, issue_we, issue_hilo, flush, clear_req;
    logic          rs_busy, rt_busy, hilo_busy, clear_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] m_gpr [NR];
    logic [DW-1:0] m_hi, m_lo;
    bit            m_busy [NR];
    bit            m_hbusy;
    bit            m_clearing;
    int            m_cnt;

    always #5 clock = ~clock;

    regfile_sb dut (
        .clock(clock), .reset(reset), .rs(rs), .rt(rt),
        .regfile_out1(regfile_out1), .regfile_out2(regfile_out2),
        .high_out(high_out), .low_out(low_out),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .hilo_we(hilo_we), .hi_data(hi_data), .lo_data(lo_data),
        .issue_we(issue_we), .issue_rd(issue_rd), .issue_hilo(issue_hilo),
        .flush(flush), .clear_req(clear_req),
        .rs_busy(rs_busy), .rt_busy(rt_busy), .hilo_busy(hilo_busy), .clear_busy(clear_busy)
    );

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_gpr[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_hi = '0; m_lo = '0; m_hbusy = 1'b0; m_clearing = 1'b0; m_cnt = 0;
    endtask

    // One rising edge of the reference model, using the inputs present at that edge.
    task automatic model_edge();
        if (m_clearing) begin
            if (m_cnt < NR) m_gpr[m_cnt] = '0;
            else if (m_cnt == NR) m_hi = '0;
            else m_lo = '0;
            m_cnt++;
            if (m_cnt == NR + 2) m_clearing = 1'b0;
        end else begin
            if (wb_we && wb_rd != 0) m_gpr[wb_rd] = wb_data;
            if (hilo_we) begin m_hi = hi_data; m_lo = lo_data; end
            if (flush || clear_req) begin
                for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
                m_hbusy = 1'b0;
            end else begin
                if (wb_we) m_busy[wb_rd] = 1'b0;
                if (issue_we && issue_rd != 0) m_busy[issue_rd] = 1'b1;
                if (hilo_we) m_hbusy = 1'b0;
                if (issue_hilo) m_hbusy = 1'b1;
            end
            if (clear_req) begin m_clearing = 1'b1; m_cnt = 0; end
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP && !m_clearing && wb_we && wb_rd == a) return wb_data;
        return m_gpr[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (BYP && !m_clearing && wb_we && wb_rd == a && !(issue_we && issue_rd == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [DW-1:0] exp_hi();
        return (BYP && !m_clearing && hilo_we) ? hi_data : m_hi;
    endfunction

    function automatic logic [DW-1:0] exp_lo();
        return (BYP && !m_clearing && hilo_we) ? lo_data : m_lo;
    endfunction

    function automatic bit exp_hbusy();
        return (BYP && !m_clearing && hilo_we && !issue_hilo) ? 1'b0 : m_hbusy;
    endfunction

    task automatic idle_inputs();
        wb_we = 1'b0; hilo_we = 1'b0; issue_we = 1'b0; issue_hilo = 1'b0;
        flush = 1'b0; clear_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        wb_rd = '0; wb_data = '0; hi_data = '0; lo_data = '0; issue_rd = '0; rs = '0; rt = '0;
        reset = 1'b1;
        model_reset();
        #2;
        for (int a = 0; a < NR; a++) begin
            rs = AW'(a); rt = AW'(NR - 1 - a); #1;
            n_cmp++; if (regfile_out1 !== '0) begin n_fail++; $display("FAIL reset_out1[%0d]: got %h expected 0", a, regfile_out1); end
            n_cmp++; if (regfile_out2 !== '0) begin n_fail++; $display("FAIL reset_out2[%0d]: got %h expected 0", a, regfile_out2); end
            n_cmp++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rs_busy[%0d]: got %b expected 0", a, rs_busy); end
        end
        n_cmp++; if (high_out !== '0 || low_out !== '0) begin n_fail++; $display("FAIL reset_hilo: got %h/%h expected 0/0", high_out, low_out); end
        n_cmp++; if (clear_busy !== 1'b0 || hilo_busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got clear_busy=%b hilo_busy=%b expected 0/0", clear_busy, hilo_busy); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        idle_inputs(); rs = 5'd5; #1;
        n_cmp++; if (regfile_out1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_rd5: got %h expected deadbeef", regfile_out1); end
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        tick();
        idle_inputs(); rs = 5'd0; rt = 5'd5; #1;
        n_cmp++; if (regfile_out1 !== 32'h0) begin n_fail++; $display("FAIL write_rd0: got %h expected 0", regfile_out1); end
        n_cmp++; if (regfile_out2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_port2: got %h expected deadbeef", regfile_out2); end
    endtask

    task automatic test_scoreboard();
        rs = 5'd7; rt = 5'd7;
        issue_we = 1'b1; issue_rd = 5'd7;
        tick(); idle_inputs(); #1;
        n_cmp++; if (rs_busy !== 1'b1) begin n_fail++; $display("FAIL sb_issue: got %b expected 1", rs_busy); end
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
        tick(); idle_inputs(); #1;
        n_cmp++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL sb_writeback: got %b expected 0", rs_busy); end
        issue_we = 1'b1; issue_rd = 5'd7; wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h78;
        tick(); idle_inputs(); #1;
        n_cmp++; if (rs_busy !== 1'b1) begin n_fail++; $display("FAIL sb_same_edge_rs: got %b expected 1", rs_busy); end
        n_cmp++; if (rt_busy !== 1'b1) begin n_fail++; $display("FAIL sb_same_edge_rt: got %b expected 1", rt_busy); end
        issue_we = 1'b1; issue_rd = 5'd0;
        tick(); idle_inputs(); rs = 5'd0; #1;
        n_cmp++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL sb_rd0: got %b expected 0", rs_busy); end
    endtask

    task automatic test_hilo();
        hilo_we = 1'b1; hi_data = 32'h1; lo_data = 32'h2;
        tick(); idle_inputs(); #1;
        n_cmp++; if (high_out !== 32'h1 || low_out !== 32'h2) begin n_fail++; $display("FAIL hilo_write: got %h/%h expected 1/2", high_out, low_out); end
        issue_hilo = 1'b1;
        tick(); idle_inputs(); #1;
        n_cmp++; if (hilo_busy !== 1'b1) begin n_fail++; $display("FAIL hilo_issue: got %b expected 1", hilo_busy); end
        flush = 1'b1;
        tick(); idle_inputs(); #1;
        n_cmp++; if (hilo_busy !== 1'b0) begin n_fail++; $display("FAIL hilo_flush: got %b expected 0", hilo_busy); end
        n_cmp++; if (high_out !== 32'h1 || low_out !== 32'h2) begin n_fail++; $display("FAIL hilo_after_flush: got %h/%h expected 1/2", high_out, low_out); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] old;
        issue_we = 1'b1; issue_rd = 5'd3;
        tick(); idle_inputs();
        old = m_gpr[3];
        rs = 5'd3; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hA5; #1;
        n_cmp++; if (regfile_out1 !== (BYP ? 32'hA5 : old)) begin n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", regfile_out1, BYP ? 32'hA5 : old); end
        n_cmp++; if (rs_busy !== !BYP) begin n_fail++; $display("FAIL bypass_busy: got %b expected %b", rs_busy, !BYP); end
        tick(); idle_inputs(); #1;
        n_cmp++; if (regfile_out1 !== 32'hA5) begin n_fail++; $display("FAIL bypass_next_cycle: got %h expected a5", regfile_out1); end
        n_cmp++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL bypass_busy_after: got %b expected 0", rs_busy); end
    endtask

    task automatic test_clear();
        int cyc;
        for (int a = 1; a < NR; a++) begin
            wb_we = 1'b1; wb_rd = AW'(a); wb_data = $urandom | 32'h1;
            tick();
        end
        idle_inputs();
        hilo_we = 1'b1; hi_data = 32'h1234; lo_data = 32'h5678;
        tick(); idle_inputs();
        clear_req = 1'b1;
        tick(); idle_inputs();
        cyc = 0;
        while (clear_busy === 1'b1 && cyc < 100) begin
            if (cyc == 10) begin wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hFFFF; end
            if (cyc == 12) clear_req = 1'b1;
            rs = AW'($urandom_range(0, NR - 1));
            #1;
            n_cmp++; if (regfile_out1 !== exp_rd(rs)) begin n_fail++; $display("FAIL clear_partial[%0d] rs=%0d: got %h expected %h", cyc, rs, regfile_out1, exp_rd(rs)); end
            tick(); idle_inputs();
            cyc++;
        end
        n_cmp++; if (cyc != NR + 2) begin n_fail++; $display("FAIL clear_duration: got %0d cycles expected %0d", cyc, NR + 2); end
        for (int a = 0; a < NR; a++) begin
            rs = AW'(a); #1;
            n_cmp++; if (regfile_out1 !== '0) begin n_fail++; $display("FAIL clear_result[%0d]: got %h expected 0", a, regfile_out1); end
        end
        n_cmp++; if (high_out !== '0 || low_out !== '0) begin n_fail++; $display("FAIL clear_hilo: got %h/%h expected 0/0", high_out, low_out); end
    endtask

    task automatic test_reset_mid_clear();
        wb_we = 1'b1; wb_rd = 5'd20; wb_data = 32'hCAFE0020;
        tick(); idle_inputs();
        hilo_we = 1'b1; hi_data = 32'h9; lo_data = 32'hA;
        tick(); idle_inputs();
        issue_we = 1'b1; issue_rd = 5'd20; clear_req = 1'b1;
        tick(); idle_inputs();
        for (int c = 0; c < 10; c++) tick();
        n_cmp++; if (clear_busy !== 1'b1) begin n_fail++; $display("FAIL midclear_active: got %b expected 1", clear_busy); end
        rs = 5'd20; rt = 5'd31;
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (clear_busy !== 1'b0) begin n_fail++; $display("FAIL midclear_abort: got %b expected 0", clear_busy); end
        n_cmp++; if (regfile_out1 !== '0 || regfile_out2 !== '0) begin n_fail++; $display("FAIL midclear_reads: got %h/%h expected 0/0", regfile_out1, regfile_out2); end
        n_cmp++; if (high_out !== '0 || low_out !== '0) begin n_fail++; $display("FAIL midclear_hilo: got %h/%h expected 0/0", high_out, low_out); end
        @(negedge clock);
        reset = 1'b0;
        tick();
        n_cmp++; if (clear_busy !== 1'b0) begin n_fail++; $display("FAIL midclear_no_resume: got %b expected 0", clear_busy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            wb_we      = $urandom_range(0, 1);
            wb_rd      = AW'($urandom_range(0, NR - 1));
            wb_data    = $urandom;
            hilo_we    = ($urandom_range(0, 3) == 0);
            hi_data    = $urandom;
            lo_data    = $urandom;
            issue_we   = $urandom_range(0, 1);
            issue_rd   = ($urandom_range(0, 3) == 0) ? wb_rd : AW'($urandom_range(0, NR - 1));
            issue_hilo = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 31) == 0);
            clear_req  = ($urandom_range(0, 149) == 0);
            rs         = ($urandom_range(0, 1) == 0) ? wb_rd : AW'($urandom_range(0, NR - 1));
            rt         = ($urandom_range(0, 2) == 0) ? issue_rd : AW'($urandom_range(0, NR - 1));
            #1;
            n_cmp++; if (regfile_out1 !== exp_rd(rs)) begin n_fail++; $display("FAIL rand_out1[%0d] rs=%0d: got %h expected %h", n, rs, regfile_out1, exp_rd(rs)); end
            n_cmp++; if (regfile_out2 !== exp_rd(rt)) begin n_fail++; $display("FAIL rand_out2[%0d] rt=%0d: got %h expected %h", n, rt, regfile_out2, exp_rd(rt)); end
            n_cmp++; if (high_out !== exp_hi() || low_out !== exp_lo()) begin n_fail++; $display("FAIL rand_hilo[%0d]: got %h/%h expected %h/%h", n, high_out, low_out, exp_hi(), exp_lo()); end
            n_cmp++; if (rs_busy !== exp_busy(rs)) begin n_fail++; $display("FAIL rand_rs_busy[%0d] rs=%0d: got %b expected %b", n, rs, rs_busy, exp_busy(rs)); end
            n_cmp++; if (rt_busy !== exp_busy(rt)) begin n_fail++; $display("FAIL rand_rt_busy[%0d] rt=%0d: got %b expected %b", n, rt, rt_busy, exp_busy(rt)); end
            n_cmp++; if (hilo_busy !== exp_hbusy()) begin n_fail++; $display("FAIL rand_hilo_busy[%0d]: got %b expected %b", n, hilo_busy, exp_hbusy()); end
            n_cmp++; if (clear_busy !== m_clearing) begin n_fail++; $display("FAIL rand_clear_busy[%0d]: got %b expected %b", n, clear_busy, m_clearing); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_hilo();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
